// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings and widths for the pipeline hazard control logic.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int         LU_CNT_W = 2;

    typedef logic [LU_CNT_W-1:0] lu_cnt_t;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Stall-cycle and flush-event performance counters, both wrapping modulo 2^32.
module hazard_perf_cnt (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_pc_stall,
    input  logic        i_if_id_flush,
    output logic [31:0] o_stall_cycles,
    output logic [31:0] o_flush_count
);

    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_count;

    // The reset-time flush is never counted: the async reset holds both at zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (i_pc_stall)    r_stall_cycles <= r_stall_cycles + 32'd1;
            if (i_if_id_flush) r_flush_count  <= r_flush_count + 32'd1;
        end
    end

    assign o_stall_cycles = r_stall_cycles;
    assign o_flush_count  = r_flush_count;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Load-use / taken-branch / data-memory-wait hazard controller for the 5-stage core.
// Optional counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl_unit
    import pipeline_ctrl_pkg::*;
#(
    parameter int LU_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt,
    input  logic        ex_branch_taken,
    input  logic        dmem_busy,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_stall,
    output logic [1:0]  state_o,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);

    localparam lu_cnt_t LU_INIT = lu_cnt_t'(LU_CYCLES - 1);

    state_e  r_state, r_ret_state;
    lu_cnt_t r_lu_cnt;
    state_e  w_next_state, w_next_ret;
    lu_cnt_t w_next_cnt;
    state_e  w_eff;
    logic    w_hazard;

    assign w_hazard = ex_mem_read && (ex_rt != REG_ZERO) &&
                      ((id_uses_rs && (id_rs == ex_rt)) ||
                       (id_uses_rt && (id_rt == ex_rt)));

    // A memory wait is transparent: decisions resume from the state it interrupted.
    assign w_eff = (r_state == ST_MEM_WAIT) ? r_ret_state : r_state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_RUN;
            r_ret_state <= ST_RUN;
            r_lu_cnt    <= '0;
        end else begin
            r_state     <= w_next_state;
            r_ret_state <= w_next_ret;
            r_lu_cnt    <= w_next_cnt;
        end
    end

    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_stall     = 1'b0;
        w_next_state = r_state;
        w_next_ret   = r_ret_state;
        w_next_cnt   = r_lu_cnt;

        if (dmem_busy) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            ex_stall     = 1'b1;
            w_next_state = ST_MEM_WAIT;
            w_next_ret   = (w_eff == ST_LU_STALL) ? ST_LU_STALL : ST_RUN;
        end else begin
            case (w_eff)
                ST_RUN: begin
                    w_next_state = ST_RUN;
                    if (ex_branch_taken) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (w_hazard) begin
                        pc_stall    = 1'b1;
                        if_id_stall = 1'b1;
                        id_ex_flush = 1'b1;
                        if (LU_CYCLES > 1) begin
                            w_next_state = ST_LU_STALL;
                            w_next_cnt   = LU_INIT;
                        end
                    end
                end
                ST_LU_STALL: begin
                    if (ex_branch_taken) begin
                        if_id_flush  = 1'b1;
                        id_ex_flush  = 1'b1;
                        w_next_state = ST_RUN;
                        w_next_cnt   = '0;
                    end else begin
                        pc_stall     = 1'b1;
                        if_id_stall  = 1'b1;
                        id_ex_flush  = 1'b1;
                        w_next_cnt   = r_lu_cnt - lu_cnt_t'(1);
                        w_next_state = (r_lu_cnt == lu_cnt_t'(1)) ? ST_RUN : ST_LU_STALL;
                    end
                end
                default: begin
                    w_next_state = ST_RUN;
                    w_next_ret   = ST_RUN;
                    w_next_cnt   = '0;
                end
            endcase
        end

        // While reset is held both pipeline registers are bubbled and nothing stalls.
        if (!reset) begin
            pc_stall    = 1'b0;
            if_id_stall = 1'b0;
            ex_stall    = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end
    end

    assign state_o = r_state;

`ifdef HAZARD_PERF_CNT_EN
    hazard_perf_cnt u_perf_cnt (
        .i_clk          (clk),
        .i_rst_n        (reset),
        .i_pc_stall     (pc_stall),
        .i_if_id_flush  (if_id_flush),
        .o_stall_cycles (stall_cycles),
        .o_flush_count  (flush_count)
    );
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench driving two controllers (LU_CYCLES=1 and 3) with the same stimulus.
module tb_hazard_ctrl_unit;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    // Expected control vectors: {pc_stall, if_id_stall, if_id_flush, id_ex_flush, ex_stall}
    localparam logic [4:0] O_NONE = 5'b00000;
    localparam logic [4:0] O_LU   = 5'b11010;
    localparam logic [4:0] O_BR   = 5'b00110;
    localparam logic [4:0] O_MEM  = 5'b11001;
    localparam logic [4:0] O_RST  = 5'b00110;
    localparam logic [1:0] S_RUN = 2'd0, S_LU = 2'd1, S_MW = 2'd2;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_uses_rs, id_uses_rt, ex_mem_read, ex_branch_taken, dmem_busy;

    logic        pc1, ifs1, iff1, idf1, exs1;
    logic [1:0]  st1;
    logic [31:0] sc1, fc1;
    logic        pc3, ifs3, iff3, idf3, exs3;
    logic [1:0]  st3;
    logic [31:0] sc3, fc3;

    int n_checks = 0;
    int n_fail   = 0;
    int m_sc1 = 0, m_fc1 = 0, m_sc3 = 0, m_fc3 = 0;

    always #5 clk = ~clk;

    hazard_ctrl_unit #(.LU_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .ex_branch_taken(ex_branch_taken), .dmem_busy(dmem_busy),
        .pc_stall(pc1), .if_id_stall(ifs1), .if_id_flush(iff1),
        .id_ex_flush(idf1), .ex_stall(exs1), .state_o(st1),
        .stall_cycles(sc1), .flush_count(fc1)
    );

    hazard_ctrl_unit #(.LU_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .ex_branch_taken(ex_branch_taken), .dmem_busy(dmem_busy),
        .pc_stall(pc3), .if_id_stall(ifs3), .if_id_flush(iff3),
        .id_ex_flush(idf3), .ex_stall(exs3), .state_o(st3),
        .stall_cycles(sc3), .flush_count(fc3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // kind: 0 none, 1 rs match, 2 ex_rt=0, 3 rt match, 4 match but unused, 5 not a load
    task automatic drive_kind(input int kind);
        ex_mem_read = 1'b0; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        case (kind)
            1: begin ex_mem_read = 1'b1; ex_rt = 5'd8;  id_rs = 5'd8;  id_uses_rs = 1'b1; end
            2: begin ex_mem_read = 1'b1; ex_rt = 5'd0;  id_rs = 5'd0;  id_uses_rs = 1'b1; end
            3: begin ex_mem_read = 1'b1; ex_rt = 5'd12; id_rt = 5'd12; id_uses_rt = 1'b1; id_rs = 5'd3; id_uses_rs = 1'b1; end
            4: begin ex_mem_read = 1'b1; ex_rt = 5'd8;  id_rs = 5'd8;  id_rt = 5'd8; end
            5: begin ex_mem_read = 1'b0; ex_rt = 5'd8;  id_rs = 5'd8;  id_uses_rs = 1'b1; end
            default: ;
        endcase
    endtask

    task automatic step(input string tag, input logic rst_v, input int kind,
                        input logic br, input logic busy,
                        input logic [6:0] e1, input logic [6:0] e3);
        @(negedge clk);
        reset = rst_v;
        drive_kind(kind);
        ex_branch_taken = br;
        dmem_busy = busy;
        #2;
        check({tag, "/d1.ctl"}, {25'd0, st1, pc1, ifs1, iff1, idf1, exs1}, {25'd0, e1});
        check({tag, "/d3.ctl"}, {25'd0, st3, pc3, ifs3, iff3, idf3, exs3}, {25'd0, e3});
        @(posedge clk);
        #1;
        if (rst_v) begin
            m_sc1 += int'(e1[4]); m_fc1 += int'(e1[2]);
            m_sc3 += int'(e3[4]); m_fc3 += int'(e3[2]);
        end else begin
            m_sc1 = 0; m_fc1 = 0; m_sc3 = 0; m_fc3 = 0;
        end
        check({tag, "/d1.stall_cycles"}, sc1, PERF_EN ? 32'(m_sc1) : 32'd0);
        check({tag, "/d1.flush_count"},  fc1, PERF_EN ? 32'(m_fc1) : 32'd0);
        check({tag, "/d3.stall_cycles"}, sc3, PERF_EN ? 32'(m_sc3) : 32'd0);
        check({tag, "/d3.flush_count"},  fc3, PERF_EN ? 32'(m_fc3) : 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        drive_kind(0);
        ex_branch_taken = 1'b0;
        dmem_busy = 1'b0;

        for (int i = 0; i < 3; i++)
            step("reset", 1'b0, 0, 1'b0, 1'b0, {S_RUN, O_RST}, {S_RUN, O_RST});
        step("release", 1'b1, 0, 1'b0, 1'b0, {S_RUN, O_NONE}, {S_RUN, O_NONE});

        step("lu_rs.c0", 1'b1, 1, 1'b0, 1'b0, {S_RUN, O_LU},   {S_RUN, O_LU});
        step("lu_rs.c1", 1'b1, 0, 1'b0, 1'b0, {S_RUN, O_NONE}, {S_LU,  O_LU});
        step("lu_rs.c2", 1'b1, 0, 1'b0, 1'b0, {S_RUN, O_NONE}, {S_LU,  O_LU});
        step("lu_rs.c3", 1'b1, 0, 1'b0, 1'b0, {S_RUN, O_NONE}, {S_RUN, O_NONE});

        step("rt_zero",  1'b1, 2, 1'b0, 1'b0, {S_RUN, O_NONE}, {S_RUN, O_NONE});
        step("lu_rt.c0", 1'b1, 3, 1'b0, 1'b0, {S_RUN, O_LU},   {S_RUN, O_LU});
        step("lu_rt.c1", 1'b1, 0, 1'b0, 1'b0, {S_RUN, O_NONE}, {S_LU,  O_LU});
        step("lu_rt.c2", 1'b1, 0, 1'b0, 1'b0, {S_RUN, O_NONE}, {S_LU,  O_LU});
        step("no_use",   1'b1, 4, 1'b0, 1'b0, {S_RUN, O_NONE}, {S_RUN, O_NONE});
        step("no_load",  1'b1, 5, 1'b0, 1'b0, {S_RUN, O_NONE}, {S_RUN, O_NONE});

        step("br_haz",   1'b1, 1, 1'b1, 1'b0, {S_RUN, O_BR},   {S_RUN, O_BR});
        step("br_after", 1'b1, 0, 1'b0, 1'b0, {S_RUN, O_NONE}, {S_RUN, O_NONE});

        step("mem.c0", 1'b1, 1, 1'b0, 1'b0, {S_RUN, O_LU},  {S_RUN, O_LU});
        step("mem.c1", 1'b1, 0, 1'b0, 1'b1, {S_RUN, O_MEM}, {S_LU,  O_MEM});
        step("mem.c2", 1'b1, 0, 1'b0, 1'b1, {S_MW,  O_MEM}, {S_MW,  O_MEM});
        step("mem.c3", 1'b1, 0, 1'b0, 1'b1, {S_MW,  O_MEM}, {S_MW,  O_MEM});
        step("mem.c4", 1'b1, 0, 1'b0, 1'b1, {S_MW,  O_MEM}, {S_MW,  O_MEM});
        step("mem.c5", 1'b1, 0, 1'b0, 1'b0, {S_MW,  O_NONE}, {S_MW, O_LU});
        step("mem.c6", 1'b1, 0, 1'b0, 1'b0, {S_RUN, O_NONE}, {S_LU, O_LU});
        step("mem.c7", 1'b1, 0, 1'b0, 1'b0, {S_RUN, O_NONE}, {S_RUN, O_NONE});

        step("busy_br.c0", 1'b1, 0, 1'b1, 1'b1, {S_RUN, O_MEM},  {S_RUN, O_MEM});
        step("busy_br.c1", 1'b1, 0, 1'b1, 1'b0, {S_MW,  O_BR},   {S_MW,  O_BR});
        step("busy_br.c2", 1'b1, 0, 1'b0, 1'b0, {S_RUN, O_NONE}, {S_RUN, O_NONE});

        step("lu_br.c0", 1'b1, 1, 1'b0, 1'b0, {S_RUN, O_LU},   {S_RUN, O_LU});
        step("lu_br.c1", 1'b1, 0, 1'b1, 1'b0, {S_RUN, O_BR},   {S_LU,  O_BR});
        step("lu_br.c2", 1'b1, 0, 1'b0, 1'b0, {S_RUN, O_NONE}, {S_RUN, O_NONE});

        step("rst_lu.c0", 1'b1, 1, 1'b0, 1'b0, {S_RUN, O_LU},   {S_RUN, O_LU});
        step("rst_lu.c1", 1'b0, 0, 1'b0, 1'b0, {S_RUN, O_RST},  {S_RUN, O_RST});
        step("rst_lu.c2", 1'b1, 0, 1'b0, 1'b0, {S_RUN, O_NONE}, {S_RUN, O_NONE});

        step("rst_mw.c0", 1'b1, 0, 1'b0, 1'b1, {S_RUN, O_MEM},  {S_RUN, O_MEM});
        step("rst_mw.c1", 1'b0, 0, 1'b0, 1'b0, {S_RUN, O_RST},  {S_RUN, O_RST});
        step("rst_mw.c2", 1'b1, 0, 1'b0, 1'b0, {S_RUN, O_NONE}, {S_RUN, O_NONE});

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
